// File: rtl/cv32e40p_hwlp_sequencer.sv
// Hardware-loop register sets and loop-back jump sequencer for the ID stage.
// On retirement of an instruction at a loop end address, the matching loop
// count is decremented. If iterations remain, a redirect to the loop start is
// requested and held until the prefetcher acknowledges it or the controller
// flushes it.
module cv32e40p_hwlp_sequencer #(
  parameter int unsigned N_REGSETS = 2,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned ADDR_W   = 32,
  localparam int unsigned RID_W    = (N_REGSETS > 1) ? $clog2(N_REGSETS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [2:0]                    hwlp_we_i,
  input  logic [RID_W-1:0]              hwlp_regid_i,
  input  logic [ADDR_W-1:0]             hwlp_start_data_i,
  input  logic [ADDR_W-1:0]             hwlp_end_data_i,
  input  logic [CNT_W-1:0]              hwlp_cnt_data_i,
  input  logic                          is_decoding_i,
  input  logic                          id_valid_i,
  input  logic                          id_kill_i,
  input  logic [ADDR_W-1:0]             pc_id_i,
  input  logic                          flush_i,
  input  logic                          jump_ack_i,
  output logic                          jump_req_o,
  output logic [ADDR_W-1:0]             jump_target_o,
  output logic                          id_stall_o,
  output logic [N_REGSETS*ADDR_W-1:0]   hwlp_start_o,
  output logic [N_REGSETS*ADDR_W-1:0]   hwlp_end_o,
  output logic [N_REGSETS*CNT_W-1:0]    hwlp_cnt_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    JUMP_PEND = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [N_REGSETS-1:0][ADDR_W-1:0] start_q, start_d;
  logic [N_REGSETS-1:0][ADDR_W-1:0] end_q, end_d;
  logic [N_REGSETS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]                target_q;
  logic [ADDR_W-1:0]                take_target;
  logic                             retire;
  logic                             take;

  assign retire = is_decoding_i && id_valid_i && !id_kill_i;

  // Loop evaluation (set 0 first) followed by register writes, which override decrements
  always_comb begin
    start_d     = start_q;
    end_d       = end_q;
    cnt_d       = cnt_q;
    take        = 1'b0;
    take_target = '0;
    if (state_q == IDLE && retire) begin
      for (int unsigned k = 0; k < N_REGSETS; k++) begin
        if (!take && pc_id_i == end_q[k] && cnt_q[k] != '0) begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
          if (cnt_q[k] > CNT_W'(1)) begin
            take        = 1'b1;
            take_target = start_q[k];
          end
        end
      end
    end
    for (int unsigned k = 0; k < N_REGSETS; k++) begin
      if (hwlp_regid_i == RID_W'(k)) begin
        if (hwlp_we_i[0]) start_d[k] = hwlp_start_data_i;
        if (hwlp_we_i[1]) end_d[k]   = hwlp_end_data_i;
        if (hwlp_we_i[2]) cnt_d[k]   = hwlp_cnt_data_i;
      end
    end
  end

  // Loop register sets
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect target, captured only when a loop-back is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= '0;
    end else if (take) begin
      target_q <= take_target;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush and ack both release a pending jump
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (take) state_d = JUMP_PEND;
      JUMP_PEND: if (flush_i || jump_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the state flop
  always_comb begin
    jump_req_o = 1'b0;
    id_stall_o = 1'b0;
    if (state_q == JUMP_PEND) begin
      jump_req_o = 1'b1;
      id_stall_o = 1'b1;
    end
  end

  assign jump_target_o = target_q;
  assign hwlp_start_o  = start_q;
  assign hwlp_end_o    = end_q;
  assign hwlp_cnt_o    = cnt_q;

endmodule

// File: tb/tb_cv32e40p_hwlp_sequencer.sv
// Directed and randomized bench for the hardware-loop sequencer, checked
// against a rule-level reference model of the two loop sets.
module tb_cv32e40p_hwlp_sequencer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  we;
  logic        regid;
  logic [31:0] start_data;
  logic [31:0] end_data;
  logic [31:0] cnt_data;
  logic        is_decoding;
  logic        id_valid;
  logic        id_kill;
  logic [31:0] pc_id;
  logic        flush;
  logic        jump_ack;
  logic        jump_req;
  logic [31:0] jump_target;
  logic        id_stall;
  logic [63:0] hwlp_start;
  logic [63:0] hwlp_end;
  logic [63:0] hwlp_cnt;

  cv32e40p_hwlp_sequencer #(.N_REGSETS(2), .CNT_W(32)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .hwlp_start_data_i (start_data),
    .hwlp_end_data_i   (end_data),
    .hwlp_cnt_data_i   (cnt_data),
    .is_decoding_i     (is_decoding),
    .id_valid_i        (id_valid),
    .id_kill_i         (id_kill),
    .pc_id_i           (pc_id),
    .flush_i           (flush),
    .jump_ack_i        (jump_ack),
    .jump_req_o        (jump_req),
    .jump_target_o     (jump_target),
    .id_stall_o        (id_stall),
    .hwlp_start_o      (hwlp_start),
    .hwlp_end_o        (hwlp_end),
    .hwlp_cnt_o        (hwlp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural view of the loop sets and pending redirect
  logic [31:0] m_start [2];
  logic [31:0] m_end   [2];
  logic [31:0] m_cnt   [2];
  bit          m_pend;
  logic [31:0] m_tgt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("jump_req", 64'(jump_req), 64'(m_pend));
    check("id_stall", 64'(id_stall), 64'(m_pend));
    check("jump_target", 64'(jump_target), 64'(m_tgt));
    check("start", hwlp_start, {m_start[1], m_start[0]});
    check("end", hwlp_end, {m_end[1], m_end[0]});
    check("cnt", hwlp_cnt, {m_cnt[1], m_cnt[0]});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_start[i] = '0;
      m_end[i]   = '0;
      m_cnt[i]   = '0;
    end
    m_pend = 1'b0;
    m_tgt  = '0;
  endtask

  task automatic idle_inputs();
    we = 3'b000; regid = 1'b0; start_data = '0; end_data = '0; cnt_data = '0;
    is_decoding = 1'b0; id_valid = 1'b0; id_kill = 1'b0; pc_id = '0;
    flush = 1'b0; jump_ack = 1'b0;
  endtask

  // One clock: predict from the rules, advance, then compare everything
  task automatic cyc();
    logic [31:0] ns [2];
    logic [31:0] ne [2];
    logic [31:0] nc [2];
    logic [31:0] nt;
    bit          np;
    bit          taken;
    ns = m_start; ne = m_end; nc = m_cnt; nt = m_tgt; np = m_pend; taken = 1'b0;
    if (!m_pend) begin
      if (is_decoding && id_valid && !id_kill) begin
        for (int i = 0; i < 2; i++) begin
          if (!taken && pc_id == m_end[i] && m_cnt[i] != 0) begin
            nc[i] = m_cnt[i] - 1;
            if (m_cnt[i] > 1) begin
              taken = 1'b1;
              nt    = m_start[i];
            end
          end
        end
        np = taken;
      end
    end else if (flush || jump_ack) begin
      np = 1'b0;
    end
    if (we[0]) ns[regid] = start_data;
    if (we[1]) ne[regid] = end_data;
    if (we[2]) nc[regid] = cnt_data;
    @(posedge clk);
    #1;
    m_start = ns; m_end = ne; m_cnt = nc; m_tgt = nt; m_pend = np;
    check_all();
  endtask

  task automatic wr(input logic rid, input logic [2:0] w, input logic [31:0] s,
                    input logic [31:0] e, input logic [31:0] c);
    regid = rid; we = w; start_data = s; end_data = e; cnt_data = c;
    cyc();
    we = 3'b000;
  endtask

  task automatic retire_at(input logic [31:0] pc);
    is_decoding = 1'b1; id_valid = 1'b1; pc_id = pc;
    cyc();
    is_decoding = 1'b0; id_valid = 1'b0;
  endtask

  task automatic ack_cycle();
    jump_ack = 1'b1;
    cyc();
    jump_ack = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a [4];
    a[0] = 32'h100; a[1] = 32'h10C; a[2] = 32'h120; a[3] = 32'h200;
    return a[$urandom_range(0, 3)];
  endfunction

  initial begin
    idle_inputs();
    model_clear();
    rst_n = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1 single loop
    wr(1'b0, 3'b111, 32'h100, 32'h10C, 32'd3);
    retire_at(32'h10C);
    check("t1_req1", 64'(jump_req), 64'd1);
    check("t1_tgt1", 64'(jump_target), 64'h100);
    ack_cycle();
    retire_at(32'h10C);
    check("t1_cnt1", hwlp_cnt[31:0], 64'd1);
    ack_cycle();
    retire_at(32'h10C);
    check("t1_noreq", 64'(jump_req), 64'd0);
    check("t1_cnt0", hwlp_cnt[31:0], 64'd0);

    // T2 nested loops sharing an end address
    wr(1'b0, 3'b110, 32'h0, 32'h120, 32'd1);
    wr(1'b1, 3'b111, 32'h200, 32'h120, 32'd2);
    retire_at(32'h120);
    check("t2_cnt", hwlp_cnt, {32'd1, 32'd0});
    check("t2_tgt", 64'(jump_target), 64'h200);
    ack_cycle();

    // T3 delayed ack
    wr(1'b0, 3'b111, 32'h100, 32'h10C, 32'd3);
    retire_at(32'h10C);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t3_hold_req", 64'(jump_req), 64'd1);
      check("t3_hold_tgt", 64'(jump_target), 64'h100);
    end
    ack_cycle();
    check("t3_released", 64'({jump_req, id_stall}), 64'd0);

    // T4 count write collides with decrement
    wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd4);
    we = 3'b100; regid = 1'b0; cnt_data = 32'd9;
    retire_at(32'h10C);
    we = 3'b000;
    check("t4_cnt", hwlp_cnt[31:0], 64'd9);
    check("t4_req", 64'(jump_req), 64'd1);
    // writes while pending never move the target
    wr(1'b0, 3'b111, 32'h300, 32'h30C, 32'd7);
    check("t4_tgt_stable", 64'(jump_target), 64'h100);
    ack_cycle();

    // T5 flush together with ack
    wr(1'b0, 3'b111, 32'h100, 32'h10C, 32'd5);
    retire_at(32'h10C);
    flush = 1'b1; jump_ack = 1'b1;
    cyc();
    flush = 1'b0; jump_ack = 1'b0;
    check("t5_req", 64'(jump_req), 64'd0);
    check("t5_cnt", hwlp_cnt[31:0], 64'd4);

    // T6 killed end instruction, then reset while a jump is pending
    wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd3);
    id_kill = 1'b1;
    retire_at(32'h10C);
    id_kill = 1'b0;
    check("t6_kill_cnt", hwlp_cnt[31:0], 64'd3);
    check("t6_kill_req", 64'(jump_req), 64'd0);
    retire_at(32'h10C);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    check("t6_rst_outs", 64'({jump_req, id_stall}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 25) begin
        we         = 3'($urandom_range(1, 7));
        regid      = 1'($urandom_range(0, 1));
        start_data = pick_addr();
        end_data   = pick_addr();
        cnt_data   = 32'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 99) < 70) begin
        is_decoding = 1'($urandom_range(0, 9) != 0);
        id_valid    = 1'($urandom_range(0, 9) != 0);
        id_kill     = 1'($urandom_range(0, 9) == 0);
        pc_id       = pick_addr();
      end
      jump_ack = 1'($urandom_range(0, 1));
      flush    = 1'($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
